// File: rtl/mode_pkg.sv
// Shared constants, state encoding and helpers for the keypad/display mode sequencer.
package mode_pkg;

  localparam logic [3:0] KEY_CLR   = 4'd10;
  localparam logic [3:0] KEY_LAP   = 4'd11;
  localparam logic [3:0] KEY_PAUSE = 4'd12;
  localparam logic [3:0] KEY_RUN   = 4'd13;
  localparam logic [3:0] KEY_OPA   = 4'd14;
  localparam logic [3:0] KEY_OPB   = 4'd15;

  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  localparam logic [31:0] MAX_SHOW = 32'd9999;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_HOLD  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;

  // Index of the last of the 14 shift steps in the converter.
  localparam logic [3:0] CONV_LAST = 4'd13;

  typedef enum logic [2:0] {
    SW_RUN,
    SW_PAUSE,
    SW_LAP,
    CALC_ENTER,
    CALC_SHOW
  } mode_state_t;

  function automatic logic [13:0] saturate_show(input logic [31:0] value);
    if (value > MAX_SHOW) return 14'd9999;
    return value[13:0];
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential 14-bit double-dabble: one add-3/shift step per cycle, 14 busy cycles.
module bcd_seq_conv
  import mode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  // Handshake: start is accepted only on a cycle with busy=0; done is high during the
  // final busy cycle and bcd is valid only while done=1; abort drops busy without done.
  logic [13:0] sh_q;
  logic [15:0] acc_q;
  logic [15:0] acc_adj;
  logic [15:0] acc_next;
  logic [3:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[14:0], sh_q[13]};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CONV_LAST) && !abort;
  assign bcd  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      sh_q   <= 14'd0;
      acc_q  <= 16'd0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else if (busy_q) begin
      acc_q <= acc_next;
      sh_q  <= {sh_q[12:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == CONV_LAST) busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      sh_q   <= bin;
      acc_q  <= 16'd0;
      cnt_q  <= 4'd0;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Keypad-driven mode sequencer: stopwatch/calculator ownership and 4-digit display feed.
module mode_sequencer
  import mode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  input  logic [31:0] sw_seconds,
  input  logic [31:0] calc_answer,
  input  logic        calc_neg,
  output logic [1:0]  sw_cmd,
  output logic        calc_mode,
  output logic        calc_key_valid,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        conv_busy
);

  mode_state_t state;
  mode_state_t next_state;
  logic [1:0]  sw_cmd_next;
  logic        clr_hit;
  logic [31:0] lap_q;
  logic [31:0] src_value;
  logic [31:0] calc_mod;
  logic        src_neg;
  logic        neg_q;
  logic [13:0] conv_bin;
  logic        conv_start;
  logic        conv_abort;
  logic        conv_done;
  logic [15:0] conv_bcd;

  always_ff @(posedge clk) begin
    if (rst) state <= SW_PAUSE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    clr_hit    = 1'b0;
    case (state)
      SW_RUN, SW_PAUSE, SW_LAP: begin
        if (key_valid) begin
          case (key_code)
            KEY_RUN:          next_state = SW_RUN;
            KEY_PAUSE:        next_state = SW_PAUSE;
            KEY_LAP:          next_state = SW_LAP;
            KEY_CLR: begin
              next_state = SW_PAUSE;
              clr_hit    = 1'b1;
            end
            KEY_OPA, KEY_OPB: next_state = CALC_ENTER;
            default:          next_state = state;
          endcase
        end
      end
      CALC_ENTER: next_state = CALC_SHOW;
      CALC_SHOW: begin
        if (key_valid && key_code == KEY_RUN) next_state = SW_PAUSE;
      end
      default: next_state = SW_PAUSE;
    endcase

    sw_cmd_next = ((next_state == SW_RUN) || (next_state == SW_LAP)) ? CMD_RUN : CMD_HOLD;
    if (clr_hit) sw_cmd_next = CMD_CLEAR;
  end

  assign calc_mode = (state == CALC_ENTER) || (state == CALC_SHOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cmd         <= CMD_CLEAR;
      calc_key_valid <= 1'b0;
      lap_q          <= 32'd0;
    end else begin
      sw_cmd         <= sw_cmd_next;
      calc_key_valid <= key_valid && (calc_mode || key_code == KEY_OPA || key_code == KEY_OPB);
      if (next_state == SW_LAP && state != SW_LAP) lap_q <= sw_seconds;
    end
  end

  // Negative results show only the last two magnitude digits, so convert mod 100 instead.
  always_comb begin
    src_value = sw_seconds;
    src_neg   = 1'b0;
    case (state)
      SW_LAP:    src_value = lap_q;
      CALC_SHOW: begin
        src_value = calc_answer;
        src_neg   = calc_neg;
      end
      default:   src_value = sw_seconds;
    endcase
    calc_mod = calc_answer % 32'd100;
    conv_bin = src_neg ? calc_mod[13:0] : saturate_show(src_value);
  end

  assign conv_abort = (next_state == CALC_ENTER);
  assign conv_start = !conv_busy && (state != CALC_ENTER) && (next_state != CALC_ENTER);

  bcd_seq_conv u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .abort (conv_abort),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else if (conv_start) neg_q <= src_neg;
  end

  // Entering CALC_ENTER blanks the display and outranks a coincident completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      {digit3, digit2, digit1, digit0} <= 16'h0000;
    end else if (conv_abort) begin
      {digit3, digit2, digit1, digit0} <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_BLANK};
    end else if (conv_done) begin
      if (neg_q) {digit3, digit2, digit1, digit0} <= {DIG_BLANK, DIG_MINUS, conv_bcd[7:0]};
      else       {digit3, digit2, digit1, digit0} <= conv_bcd;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: keypad scenarios with hand-computed display and command values.
module tb_mode_sequencer;
  import mode_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_code = 4'd0;
  logic        key_valid = 1'b0;
  logic [31:0] sw_seconds = 32'd0;
  logic [31:0] calc_answer = 32'd0;
  logic        calc_neg = 1'b0;
  logic [1:0]  sw_cmd;
  logic        calc_mode;
  logic        calc_key_valid;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic        conv_busy;
  logic [15:0] digits;

  int pass_cnt  = 0;
  int check_cnt = 0;

  assign digits = {digit3, digit2, digit1, digit0};

  mode_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .sw_seconds     (sw_seconds),
    .calc_answer    (calc_answer),
    .calc_neg       (calc_neg),
    .sw_cmd         (sw_cmd),
    .calc_mode      (calc_mode),
    .calc_key_valid (calc_key_valid),
    .digit3         (digit3),
    .digit2         (digit2),
    .digit1         (digit1),
    .digit0         (digit0),
    .conv_busy      (conv_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Moves to the first cycle of a freshly started conversion.
  task automatic sync_to_conv_start(output logic ok);
    logic seen_idle;
    seen_idle = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (!conv_busy) seen_idle = 1'b1;
      else if (seen_idle) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw_seconds = 32'd1234;
    tick();
    tick();
    check_cnt++;
    if (sw_cmd !== CMD_CLEAR) $display("FAIL reset_sw_cmd: got %0d want %0d", sw_cmd, CMD_CLEAR);
    else pass_cnt++;
    check_cnt++;
    if (calc_mode !== 1'b0 || calc_key_valid !== 1'b0)
      $display("FAIL reset_calc: got mode=%0b ckv=%0b want 0 0", calc_mode, calc_key_valid);
    else pass_cnt++;
    check_cnt++;
    if (digits !== 16'h0000 || conv_busy !== 1'b0)
      $display("FAIL reset_display: got digits=%h busy=%0b want 0000 0", digits, conv_busy);
    else pass_cnt++;
    check_cnt++;
    if (dut.state !== SW_PAUSE) $display("FAIL reset_state: got %0d want %0d", dut.state, SW_PAUSE);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    check_cnt++;
    if (sw_cmd !== CMD_HOLD || conv_busy !== 1'b1)
      $display("FAIL post_reset: got cmd=%0d busy=%0b want %0d 1", sw_cmd, conv_busy, CMD_HOLD);
    else pass_cnt++;
  endtask

  task automatic test_run();
    logic found;
    press(KEY_RUN);
    check_cnt++;
    if (sw_cmd !== CMD_RUN) $display("FAIL run_cmd: got %0d want %0d", sw_cmd, CMD_RUN);
    else pass_cnt++;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if (digits === 16'h1234) found = 1'b1;
    end
    check_cnt++;
    if (!found) $display("FAIL run_digits: got %h want 1234 within 16 cycles", digits);
    else pass_cnt++;
  endtask

  task automatic test_lap();
    logic stable;
    sw_seconds = 32'd57;
    press(KEY_LAP);
    sw_seconds = 32'd900;
    check_cnt++;
    if (sw_cmd !== CMD_RUN) $display("FAIL lap_cmd: got %0d want %0d", sw_cmd, CMD_RUN);
    else pass_cnt++;
    repeat (32) tick();
    check_cnt++;
    if (digits !== 16'h0057) $display("FAIL lap_digits: got %h want 0057", digits);
    else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (digits !== 16'h0057 || sw_cmd !== CMD_RUN) stable = 1'b0;
    end
    check_cnt++;
    if (!stable) $display("FAIL lap_hold: got digits=%h cmd=%0d want 0057 %0d", digits, sw_cmd, CMD_RUN);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    press(KEY_RUN);
    check_cnt++;
    if (sw_cmd !== CMD_RUN || dut.state !== SW_RUN)
      $display("FAIL lap_to_run: got cmd=%0d state=%0d want %0d %0d", sw_cmd, dut.state, CMD_RUN, SW_RUN);
    else pass_cnt++;
    press(KEY_CLR);
    check_cnt++;
    if (sw_cmd !== CMD_CLEAR || dut.state !== SW_PAUSE)
      $display("FAIL clr_pulse: got cmd=%0d state=%0d want %0d %0d", sw_cmd, dut.state, CMD_CLEAR, SW_PAUSE);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (sw_cmd !== CMD_HOLD) $display("FAIL clr_then_hold: got %0d want %0d", sw_cmd, CMD_HOLD);
    else pass_cnt++;
    press(4'd5);
    check_cnt++;
    if (dut.state !== SW_PAUSE || sw_cmd !== CMD_HOLD || calc_key_valid !== 1'b0)
      $display("FAIL digit_key_ignored: got state=%0d cmd=%0d ckv=%0b want %0d %0d 0",
               dut.state, sw_cmd, calc_key_valid, SW_PAUSE, CMD_HOLD);
    else pass_cnt++;
  endtask

  task automatic test_calc();
    logic found;
    calc_answer = 32'd42;
    calc_neg    = 1'b1;
    press(KEY_OPA);
    check_cnt++;
    if (calc_mode !== 1'b1 || calc_key_valid !== 1'b1)
      $display("FAIL opa_enter: got mode=%0b ckv=%0b want 1 1", calc_mode, calc_key_valid);
    else pass_cnt++;
    check_cnt++;
    if (digits !== 16'hBBBB || conv_busy !== 1'b0)
      $display("FAIL opa_blank: got digits=%h busy=%0b want bbbb 0", digits, conv_busy);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (calc_key_valid !== 1'b0 || dut.state !== CALC_SHOW || digits !== 16'hBBBB)
      $display("FAIL calc_show_entry: got ckv=%0b state=%0d digits=%h want 0 %0d bbbb",
               calc_key_valid, dut.state, digits, CALC_SHOW);
    else pass_cnt++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (digits === 16'hBA42) found = 1'b1;
    end
    check_cnt++;
    if (!found) $display("FAIL calc_neg_digits: got %h want ba42", digits);
    else pass_cnt++;
    calc_neg    = 1'b0;
    calc_answer = 32'd305;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (digits === 16'h0305) found = 1'b1;
    end
    check_cnt++;
    if (!found) $display("FAIL calc_pos_digits: got %h want 0305", digits);
    else pass_cnt++;
  endtask

  task automatic test_saturate_exit();
    logic ok;
    logic clean;
    sw_seconds = 32'd123456;
    sync_to_conv_start(ok);
    check_cnt++;
    if (!ok) $display("FAIL sat_sync: got busy=%0b want a conversion start within 40 cycles", conv_busy);
    else pass_cnt++;
    repeat (5) tick();
    press(KEY_RUN);
    check_cnt++;
    if (calc_mode !== 1'b0 || calc_key_valid !== 1'b1 || sw_cmd !== CMD_HOLD)
      $display("FAIL calc_exit: got mode=%0b ckv=%0b cmd=%0d want 0 1 %0d",
               calc_mode, calc_key_valid, sw_cmd, CMD_HOLD);
    else pass_cnt++;
    clean = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (digits !== 16'h0305 && digits !== 16'h9999) clean = 1'b0;
    end
    check_cnt++;
    if (!clean) $display("FAIL exit_no_garbage: got %h want only 0305 or 9999", digits);
    else pass_cnt++;
    check_cnt++;
    if (digits !== 16'h9999) $display("FAIL saturate: got %h want 9999", digits);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_conv();
    logic ok;
    sync_to_conv_start(ok);
    check_cnt++;
    if (!ok) $display("FAIL rst_sync: got busy=%0b want a conversion start within 40 cycles", conv_busy);
    else pass_cnt++;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_cnt++;
    if (conv_busy !== 1'b0 || digits !== 16'h0000)
      $display("FAIL rst_mid_conv: got busy=%0b digits=%h want 0 0000", conv_busy, digits);
    else pass_cnt++;
    check_cnt++;
    if (sw_cmd !== CMD_CLEAR || dut.state !== SW_PAUSE)
      $display("FAIL rst_mid_state: got cmd=%0d state=%0d want %0d %0d", sw_cmd, dut.state, CMD_CLEAR, SW_PAUSE);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_run();
    test_lap();
    test_clear();
    test_calc();
    test_saturate_exit();
    test_reset_mid_conv();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
